// File: rtl/mc_main_fsm_pkg.sv
// Shared encodings for the multicycle ARM main-control FSM: states, mux selects,
// ALU operation codes and instruction opcode fields.
package mc_main_fsm_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_MULEX    = 4'd10,
    S_MULWB    = 4'd11
  } state_t;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_DP  = 2'b01;
  localparam logic [1:0] ALUOP_MUL = 2'b10;

  localparam logic [1:0] SRCA_RD1    = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] MULOP_MUL = 4'b1001;

endpackage

// File: rtl/mc_main_fsm_mul_counter.sv
// Multiply-latency counter: loaded with 1 on start, counts while running and
// flags done on the last MULEX cycle, clearing itself as the FSM leaves MULEX.
module mc_mul_counter #(
  parameter int unsigned MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_run,
  output logic o_done
);
  localparam logic [3:0] LP_LAST = 4'(MUL_CYCLES);

  logic [3:0] r_cnt;

  assign o_done = i_run && (r_cnt == LP_LAST);

  always_ff @(posedge clk) begin
    if (reset)        r_cnt <= 4'd0;
    else if (i_start) r_cnt <= 4'd1;
    else if (o_done)  r_cnt <= 4'd0;
    else if (i_run)   r_cnt <= r_cnt + 4'd1;
  end

endmodule

// File: rtl/mc_main_fsm.sv
// Main-control FSM of the multicycle ARM core with memory ready handshake,
// iterative multiply and illegal-opcode detection.
module mc_main_fsm
  import mc_main_fsm_pkg::*;
#(
  parameter int unsigned MUL_CYCLES  = 4,
  parameter bit          MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] MulOp,
  input  logic       mem_ready,
  output logic       NextPC,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic [1:0] ALUOp,
  output logic       mul_busy,
  output logic       illegal_op
);

  state_t r_state, w_next;
  logic   w_rdy, w_mul_start, w_mul_run, w_mul_done;

  assign w_rdy       = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign w_mul_run   = (r_state == S_MULEX);
  assign w_mul_start = (r_state == S_DECODE) && (Op == OP_DP) &&
                       (Funct[5:1] == 5'b00000) && (MulOp == MULOP_MUL);

  mc_mul_counter #(.MUL_CYCLES(MUL_CYCLES)) u_mul_cnt (
    .clk     (clk),
    .reset   (reset),
    .i_start (w_mul_start),
    .i_run   (w_mul_run),
    .o_done  (w_mul_done)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    NextPC     = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = SRCA_RD1;
    ALUSrcB    = SRCB_RD2;
    ResultSrc  = RES_ALUOUT;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    ALUOp      = ALUOP_ADD;
    mul_busy   = 1'b0;
    illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = w_rdy;
        NextPC    = w_rdy;
        if (w_rdy) w_next = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (Op)
          OP_MEM: w_next = S_MEMADR;
          OP_BR:  w_next = S_BRANCH;
          OP_DP: begin
            if (w_mul_start)   w_next = S_MULEX;
            else if (Funct[5]) w_next = S_EXECUTEI;
            else               w_next = S_EXECUTER;
          end
          default: begin
            illegal_op = 1'b1;
            w_next     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB = SRCB_IMM;
        w_next  = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        if (w_rdy) w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegW      = 1'b1;
        w_next    = S_FETCH;
      end
      // MemW holds through wait states so the write stays stable until accepted
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        if (w_rdy) w_next = S_FETCH;
      end
      S_EXECUTER: begin
        ALUOp  = ALUOP_DP;
        w_next = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_DP;
        w_next  = S_ALUWB;
      end
      S_ALUWB: begin
        RegW   = 1'b1;
        w_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_ALUOUT;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        Branch    = 1'b1;
        w_next    = S_FETCH;
      end
      S_MULEX: begin
        ALUOp    = ALUOP_MUL;
        mul_busy = 1'b1;
        if (w_mul_done) w_next = S_MULWB;
      end
      S_MULWB: begin
        RegW   = 1'b1;
        w_next = S_FETCH;
      end
      default: w_next = S_FETCH;
    endcase
    // Strobes are suppressed while reset is held so nothing escapes an abandoned instruction
    if (reset) begin
      NextPC     = 1'b0;
      IRWrite    = 1'b0;
      RegW       = 1'b0;
      MemW       = 1'b0;
      Branch     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_fsm.sv
// Scoreboard bench for mc_main_fsm: per-cycle expected output vectors are queued
// with the stimulus and popped against the DUT outputs each cycle.
module tb_mc_main_fsm;

  typedef enum int {E_F, E_FR, E_D, E_DI, E_MA, E_MR, E_MWB, E_MW,
                    E_XR, E_XI, E_AWB, E_BR, E_MX, E_MLWB} exp_e;

  logic       clk = 1'b0;
  logic       reset, mem_ready, mr_nw;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] MulOp;
  logic [16:0] o0, o1, o2;

  always #5 clk = ~clk;

  logic        n0, i0, a0, r0, m0, b0, u0, l0;
  logic [1:0]  sa0, sb0, rs0, ao0;
  logic        n1, i1, a1, r1, m1, b1, u1, l1;
  logic [1:0]  sa1, sb1, rs1, ao1;
  logic        n2, i2, a2, r2, m2, b2, u2, l2;
  logic [1:0]  sa2, sb2, rs2, ao2;

  mc_main_fsm #(.MUL_CYCLES(4), .MEM_WAIT_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .mem_ready(mem_ready),
    .NextPC(n0), .IRWrite(i0), .AdrSrc(a0), .ALUSrcA(sa0), .ALUSrcB(sb0), .ResultSrc(rs0),
    .RegW(r0), .MemW(m0), .Branch(b0), .ALUOp(ao0), .mul_busy(u0), .illegal_op(l0));

  mc_main_fsm #(.MUL_CYCLES(1), .MEM_WAIT_EN(1'b1)) u_dut_m1 (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .mem_ready(mem_ready),
    .NextPC(n1), .IRWrite(i1), .AdrSrc(a1), .ALUSrcA(sa1), .ALUSrcB(sb1), .ResultSrc(rs1),
    .RegW(r1), .MemW(m1), .Branch(b1), .ALUOp(ao1), .mul_busy(u1), .illegal_op(l1));

  mc_main_fsm #(.MUL_CYCLES(4), .MEM_WAIT_EN(1'b0)) u_dut_nw (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .MulOp(MulOp), .mem_ready(mr_nw),
    .NextPC(n2), .IRWrite(i2), .AdrSrc(a2), .ALUSrcA(sa2), .ALUSrcB(sb2), .ResultSrc(rs2),
    .RegW(r2), .MemW(m2), .Branch(b2), .ALUOp(ao2), .mul_busy(u2), .illegal_op(l2));

  assign o0 = {n0, i0, a0, sa0, sb0, rs0, r0, m0, b0, ao0, u0, l0};
  assign o1 = {n1, i1, a1, sa1, sb1, rs1, r1, m1, b1, ao1, u1, l1};
  assign o2 = {n2, i2, a2, sa2, sb2, rs2, r2, m2, b2, ao2, u2, l2};

  int n_cmp = 0;
  int n_bad = 0;
  logic [16:0] sbq0[$], sbq1[$], sbq2[$];
  logic        mrq[$], rq[$];

  // {NextPC, IRWrite, AdrSrc, SrcA, SrcB, ResSrc, RegW, MemW, Branch, ALUOp, busy, illegal}
  function automatic logic [16:0] exp_out(input exp_e s, input logic mr);
    case (s)
      E_F:    return {mr, mr, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000, 2'b00, 2'b00};
      E_FR:   return {1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b10, 3'b000, 2'b00, 2'b00};
      E_D:    return {3'b000, 2'b01, 2'b10, 2'b10, 3'b000, 2'b00, 2'b00};
      E_DI:   return {3'b000, 2'b01, 2'b10, 2'b10, 3'b000, 2'b00, 2'b01};
      E_MA:   return {3'b000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b00, 2'b00};
      E_MR:   return {3'b001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00};
      E_MWB:  return {3'b000, 2'b00, 2'b00, 2'b01, 3'b100, 2'b00, 2'b00};
      E_MW:   return {3'b001, 2'b00, 2'b00, 2'b00, 3'b010, 2'b00, 2'b00};
      E_XR:   return {3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00};
      E_XI:   return {3'b000, 2'b00, 2'b01, 2'b00, 3'b000, 2'b01, 2'b00};
      E_AWB:  return {3'b000, 2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 2'b00};
      E_BR:   return {3'b000, 2'b10, 2'b01, 2'b10, 3'b001, 2'b00, 2'b00};
      E_MX:   return {3'b000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b10, 2'b10};
      E_MLWB: return {3'b000, 2'b00, 2'b00, 2'b00, 3'b100, 2'b00, 2'b00};
      default: return '0;
    endcase
  endfunction

  task automatic push(input exp_e s, input logic mr, input logic rst);
    mrq.push_back(mr);
    rq.push_back(rst);
    sbq0.push_back(exp_out(s, mr));
  endtask

  task automatic do_reset();
    reset = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] mo);
    Op = op; Funct = fn; MulOp = mo;
  endtask

  task automatic test_reset();
    logic [16:0] e;
    reset = 1'b1; mem_ready = 1'b1;
    set_instr(2'b00, 6'b001000, 4'b0000);
    for (int c = 0; c < 2; c++) begin
      e = exp_out(E_FR, 1'b1);
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL reset_dut cyc%0d: got %h want %h", c, o0, e); end
      n_cmp++;
      if (o2 !== e) begin n_bad++; $display("FAIL reset_nw cyc%0d: got %h want %h", c, o2, e); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask

  task automatic test_dp(input string nm, input logic [5:0] fn, input exp_e ex);
    logic [16:0] e;
    int c = 0;
    do_reset();
    set_instr(2'b00, fn, 4'b0000);
    push(E_F, 1, 0); push(E_D, 1, 0); push(ex, 1, 0); push(E_AWB, 1, 0); push(E_F, 1, 0);
    while (sbq0.size() > 0) begin
      mem_ready = mrq.pop_front(); reset = rq.pop_front(); e = sbq0.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL %s cyc%0d: got %h want %h", nm, c, o0, e); end
      @(posedge clk); #1; c++;
    end
  endtask

  task automatic test_ldr_wait();
    logic [16:0] e;
    int c = 0;
    do_reset();
    set_instr(2'b01, 6'b011001, 4'b0000);
    push(E_F, 0, 0); push(E_F, 0, 0); push(E_F, 1, 0); push(E_D, 1, 0); push(E_MA, 1, 0);
    push(E_MR, 0, 0); push(E_MR, 0, 0); push(E_MR, 1, 0); push(E_MWB, 1, 0); push(E_F, 0, 0);
    while (sbq0.size() > 0) begin
      mem_ready = mrq.pop_front(); reset = rq.pop_front(); e = sbq0.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL ldr_wait cyc%0d: got %h want %h", c, o0, e); end
      @(posedge clk); #1; c++;
    end
  endtask

  task automatic test_str_wait();
    logic [16:0] e;
    int c = 0;
    do_reset();
    set_instr(2'b01, 6'b011000, 4'b0000);
    push(E_F, 1, 0); push(E_D, 1, 0); push(E_MA, 1, 0);
    push(E_MW, 0, 0); push(E_MW, 0, 0); push(E_MW, 0, 0); push(E_MW, 1, 0); push(E_F, 0, 0);
    while (sbq0.size() > 0) begin
      mem_ready = mrq.pop_front(); reset = rq.pop_front(); e = sbq0.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL str_wait cyc%0d: got %h want %h", c, o0, e); end
      @(posedge clk); #1; c++;
    end
  endtask

  task automatic test_branch_illegal();
    logic [16:0] e;
    int c = 0;
    do_reset();
    set_instr(2'b10, 6'b000000, 4'b0000);
    push(E_F, 1, 0); push(E_D, 1, 0); push(E_BR, 1, 0); push(E_F, 0, 0);
    while (sbq0.size() > 0) begin
      mem_ready = mrq.pop_front(); reset = rq.pop_front(); e = sbq0.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL branch cyc%0d: got %h want %h", c, o0, e); end
      @(posedge clk); #1; c++;
    end
    do_reset(); c = 0;
    set_instr(2'b11, 6'b101001, 4'b1001);
    push(E_F, 1, 0); push(E_DI, 1, 0); push(E_F, 1, 0); push(E_DI, 1, 0); push(E_F, 0, 0);
    while (sbq0.size() > 0) begin
      mem_ready = mrq.pop_front(); reset = rq.pop_front(); e = sbq0.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL illegal cyc%0d: got %h want %h", c, o0, e); end
      @(posedge clk); #1; c++;
    end
  endtask

  task automatic test_mul();
    logic [16:0] e, e1;
    int c = 0;
    do_reset();
    set_instr(2'b00, 6'b000001, 4'b1001);
    push(E_F, 1, 0); push(E_D, 1, 0);
    push(E_MX, 1, 0); push(E_MX, 1, 0); push(E_MX, 1, 0); push(E_MX, 1, 0);
    push(E_MLWB, 1, 0); push(E_F, 1, 0);
    sbq1 = '{exp_out(E_F, 1), exp_out(E_D, 1), exp_out(E_MX, 1), exp_out(E_MLWB, 1),
             exp_out(E_F, 1), exp_out(E_D, 1), exp_out(E_MX, 1), exp_out(E_MLWB, 1)};
    while (sbq0.size() > 0) begin
      mem_ready = mrq.pop_front(); reset = rq.pop_front();
      e = sbq0.pop_front(); e1 = sbq1.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL mul4 cyc%0d: got %h want %h", c, o0, e); end
      n_cmp++;
      if (o1 !== e1) begin n_bad++; $display("FAIL mul1 cyc%0d: got %h want %h", c, o1, e1); end
      @(posedge clk); #1; c++;
    end
  endtask

  task automatic test_reset_mid_mul();
    logic [16:0] e;
    int c = 0;
    do_reset();
    set_instr(2'b00, 6'b000000, 4'b1001);
    push(E_F, 1, 0); push(E_D, 1, 0); push(E_MX, 1, 0); push(E_MX, 1, 1);
    push(E_F, 1, 0); push(E_D, 1, 0);
    push(E_MX, 1, 0); push(E_MX, 1, 0); push(E_MX, 1, 0); push(E_MX, 1, 0);
    push(E_MLWB, 1, 0); push(E_F, 0, 0);
    while (sbq0.size() > 0) begin
      mem_ready = mrq.pop_front(); reset = rq.pop_front(); e = sbq0.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o0 !== e) begin n_bad++; $display("FAIL mul_reset cyc%0d: got %h want %h", c, o0, e); end
      @(posedge clk); #1; c++;
    end
    reset = 1'b0;
  endtask

  task automatic test_nowait_ldr();
    logic [16:0] e;
    int c = 0;
    do_reset();
    mr_nw = 1'b0;
    set_instr(2'b01, 6'b011001, 4'b0000);
    sbq2 = '{exp_out(E_F, 1), exp_out(E_D, 1), exp_out(E_MA, 1), exp_out(E_MR, 1),
             exp_out(E_MWB, 1), exp_out(E_F, 1)};
    while (sbq2.size() > 0) begin
      mem_ready = 1'b0; e = sbq2.pop_front();
      @(negedge clk);
      n_cmp++;
      if (o2 !== e) begin n_bad++; $display("FAIL nowait_ldr cyc%0d: got %h want %h", c, o2, e); end
      @(posedge clk); #1; c++;
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b1; mr_nw = 1'b0;
    Op = 2'b00; Funct = 6'b0; MulOp = 4'b0;
    @(posedge clk); #1;
    test_reset();
    test_dp("add_reg", 6'b001000, E_XR);
    test_dp("add_imm", 6'b101000, E_XI);
    test_ldr_wait();
    test_str_wait();
    test_branch_illegal();
    test_mul();
    test_reset_mid_mul();
    test_nowait_ldr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
